// File: rtl/imm_ext_pkg.sv
// Shared definitions for the immediate-extension pipeline: mode encodings and default widths.
package imm_ext_pkg;

  localparam int unsigned IN_W_DEF  = 16;
  localparam int unsigned OUT_W_DEF = 32;

  typedef enum logic [1:0] {
    MODE_ZERO  = 2'b00,
    MODE_SIGN  = 2'b01,
    MODE_UPPER = 2'b10,
    MODE_RSVD  = 2'b11
  } imm_mode_e;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extender: zero, sign or upper placement; reserved mode flags err.
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int unsigned IN_W  = IN_W_DEF,
  parameter int unsigned OUT_W = OUT_W_DEF
) (
  input  logic [IN_W-1:0]  imm,
  input  logic [1:0]       mode,
  output logic [OUT_W-1:0] data,
  output logic             err
);

  localparam int unsigned PadW = OUT_W - IN_W;

  logic [OUT_W-1:0] w_zext;
  logic [OUT_W-1:0] w_hi_mask;

  assign w_zext    = OUT_W'(imm);
  // Ones in the bits above the immediate; empty when OUT_W == IN_W.
  assign w_hi_mask = ~({OUT_W{1'b1}} >> PadW);

  always_comb begin
    data = w_zext;
    err  = 1'b0;
    case (imm_mode_e'(mode))
      MODE_ZERO:  data = w_zext;
      MODE_SIGN:  data = imm[IN_W-1] ? (w_zext | w_hi_mask) : w_zext;
      MODE_UPPER: data = w_zext << PadW;
      MODE_RSVD:  err  = 1'b1;
      default:    data = w_zext;
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Immediate extender behind a 2-entry skid buffer with registered in_ready.
// Optional output-transfer counter enabled by macro IMM_EXTEND_PIPE_CNT_EN.
module imm_extend_pipe
  import imm_ext_pkg::*;
#(
  parameter int unsigned IN_W  = IN_W_DEF,
  parameter int unsigned OUT_W = OUT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_err
`ifdef IMM_EXTEND_PIPE_CNT_EN
 ,output logic [15:0]      xfer_cnt
`endif
);

  logic [OUT_W-1:0] w_ext_data;
  logic             w_ext_err;

  imm_ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .imm  (in_imm),
    .mode (in_mode),
    .data (w_ext_data),
    .err  (w_ext_err)
  );

  logic             r_main_valid, w_main_valid_d;
  logic [OUT_W-1:0] r_main_data,  w_main_data_d;
  logic             r_main_err,   w_main_err_d;
  logic             r_skid_valid, w_skid_valid_d;
  logic [OUT_W-1:0] r_skid_data,  w_skid_data_d;
  logic             r_skid_err,   w_skid_err_d;
  logic             r_in_ready,   w_in_ready_d;

  logic w_in_xfer;
  logic w_out_xfer;

  assign w_in_xfer  = in_valid & r_in_ready;
  assign w_out_xfer = r_main_valid & out_ready;

  always_comb begin
    w_main_valid_d = r_main_valid;
    w_main_data_d  = r_main_data;
    w_main_err_d   = r_main_err;
    w_skid_valid_d = r_skid_valid;
    w_skid_data_d  = r_skid_data;
    w_skid_err_d   = r_skid_err;
    if (flush) begin
      w_main_valid_d = 1'b0;
      w_skid_valid_d = 1'b0;
    end else if (w_out_xfer) begin
      if (r_skid_valid) begin
        // in_ready was low, so no new input can compete with the skid entry.
        w_main_data_d  = r_skid_data;
        w_main_err_d   = r_skid_err;
        w_skid_valid_d = 1'b0;
      end else if (w_in_xfer) begin
        w_main_data_d  = w_ext_data;
        w_main_err_d   = w_ext_err;
      end else begin
        w_main_valid_d = 1'b0;
      end
    end else if (w_in_xfer) begin
      if (r_main_valid) begin
        w_skid_valid_d = 1'b1;
        w_skid_data_d  = w_ext_data;
        w_skid_err_d   = w_ext_err;
      end else begin
        w_main_valid_d = 1'b1;
        w_main_data_d  = w_ext_data;
        w_main_err_d   = w_ext_err;
      end
    end
    w_in_ready_d = ~w_skid_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_valid <= 1'b0;
      r_main_data  <= '0;
      r_main_err   <= 1'b0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_err   <= 1'b0;
      r_in_ready   <= 1'b0;
    end else begin
      r_main_valid <= w_main_valid_d;
      r_main_data  <= w_main_data_d;
      r_main_err   <= w_main_err_d;
      r_skid_valid <= w_skid_valid_d;
      r_skid_data  <= w_skid_data_d;
      r_skid_err   <= w_skid_err_d;
      r_in_ready   <= w_in_ready_d;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_main_valid;
  assign out_data  = r_main_data;
  assign out_err   = r_main_err;

`ifdef IMM_EXTEND_PIPE_CNT_EN
  logic [15:0] r_xfer_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xfer_cnt <= '0;
    end else if (flush) begin
      r_xfer_cnt <= '0;
    end else if (w_out_xfer && (r_xfer_cnt != 16'hFFFF)) begin
      r_xfer_cnt <= r_xfer_cnt + 16'd1;
    end
  end

  assign xfer_cnt = r_xfer_cnt;
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench for imm_extend_pipe: directed vector table, corner sequences, random traffic.
`timescale 1ns/1ps
module tb_imm_extend_pipe;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b1;
  logic        flush     = 1'b0;
  logic        in_valid  = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] in_imm    = '0;
  logic [1:0]  in_mode   = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_err;
`ifdef IMM_EXTEND_PIPE_CNT_EN
  logic [15:0] xfer_cnt;
`endif

  imm_extend_pipe #(
    .IN_W  (16),
    .OUT_W (32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_imm    (in_imm),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
`ifdef IMM_EXTEND_PIPE_CNT_EN
   ,.xfer_cnt  (xfer_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference: FIFO of {err, data} results still owed to the consumer.
  logic [32:0] q[$];
  bit          m_ready = 1'b0;

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] imm;
    logic [31:0] data;
    logic        err;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [32:0] ref_ext(input logic [1:0] mode, input logic [15:0] imm);
    longint v;
    longint d;
    bit     e;
    v = longint'(imm);
    e = 1'b0;
    case (mode)
      2'd0:    d = v;
      2'd1:    d = (v >= 32768) ? v - 65536 : v;
      2'd2:    d = v * 65536;
      default: begin d = v; e = 1'b1; end
    endcase
    return {e, d[31:0]};
  endfunction

  // One clock: drive inputs, advance the reference queue, compare every visible output.
  task automatic cycle(input bit v, input logic [1:0] mode, input logic [15:0] imm,
                       input bit ordy, input bit fl);
    bit in_acc;
    bit out_acc;
    in_valid  = v;
    in_mode   = mode;
    in_imm    = imm;
    out_ready = ordy;
    flush     = fl;
    in_acc    = v && m_ready && !fl;
    out_acc   = (q.size() > 0) && ordy;
    @(posedge clk);
    #1;
    if (fl) begin
      q.delete();
    end else begin
      if (out_acc) void'(q.pop_front());
      if (in_acc) q.push_back(ref_ext(mode, imm));
    end
    m_ready = (q.size() < 2);
    chk("out_valid", out_valid, q.size() > 0);
    chk("in_ready", in_ready, m_ready);
    if (q.size() > 0) begin
      chk("out_data", out_data, q[0][31:0]);
      chk("out_err", out_err, q[0][32]);
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("rst out_valid", out_valid, 0);
    chk("rst out_data", out_data, 0);
    chk("rst out_err", out_err, 0);
    chk("rst in_ready", in_ready, 0);
`ifdef IMM_EXTEND_PIPE_CNT_EN
    chk("rst xfer_cnt", xfer_cnt, 0);
`endif
    q.delete();
    m_ready = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(0, 2'd0, 16'h0, 0, 0);
    chk("post-reset in_ready", in_ready, 1);
  endtask

  initial begin
    vecs[0] = '{2'b01, 16'h8001, 32'hFFFF8001, 1'b0};
    vecs[1] = '{2'b00, 16'h8001, 32'h00008001, 1'b0};
    vecs[2] = '{2'b10, 16'h1234, 32'h12340000, 1'b0};
    vecs[3] = '{2'b11, 16'h00FF, 32'h000000FF, 1'b1};
    vecs[4] = '{2'b01, 16'h7FFF, 32'h00007FFF, 1'b0};
    vecs[5] = '{2'b10, 16'hFFFF, 32'hFFFF0000, 1'b0};
    vecs[6] = '{2'b00, 16'hFFFF, 32'h0000FFFF, 1'b0};
    vecs[7] = '{2'b01, 16'hFFFF, 32'hFFFFFFFF, 1'b0};
    vecs[8] = '{2'b11, 16'h8000, 32'h00008000, 1'b1};

    do_reset();

    // Back-to-back vectors with the consumer always ready: one result per cycle.
    for (int i = 0; i < 9; i++) begin
      cycle(1, vecs[i].mode, vecs[i].imm, 1, 0);
      chk($sformatf("vec%0d data", i), out_data, vecs[i].data);
      chk($sformatf("vec%0d err", i), out_err, vecs[i].err);
      chk($sformatf("vec%0d in_ready", i), in_ready, 1);
    end
    cycle(0, 2'd0, 16'h0, 1, 0);
    chk("drain out_valid", out_valid, 0);

    // Backpressure: third input refused, then FIFO drain.
    cycle(1, 2'd0, 16'h1111, 0, 0);
    chk("bp1 data", out_data, 32'h00001111);
    chk("bp1 in_ready", in_ready, 1);
    cycle(1, 2'd1, 16'h8222, 0, 0);
    chk("bp2 data held", out_data, 32'h00001111);
    chk("bp2 in_ready", in_ready, 0);
    cycle(1, 2'd2, 16'h3333, 0, 0);
    chk("bp3 data held", out_data, 32'h00001111);
    chk("bp3 in_ready", in_ready, 0);
    cycle(0, 2'd0, 16'h0, 1, 0);
    chk("bp4 skid moved", out_data, 32'hFFFF8222);
    chk("bp4 in_ready", in_ready, 1);
    chk("bp4 out_valid", out_valid, 1);
    cycle(0, 2'd0, 16'h0, 1, 0);
    chk("bp5 empty", out_valid, 0);

    // Flush with both entries full and a same-cycle input.
    cycle(1, 2'd0, 16'hAAAA, 0, 0);
    cycle(1, 2'd0, 16'hBBBB, 0, 0);
    cycle(1, 2'd0, 16'h5555, 0, 1);
    chk("flush out_valid", out_valid, 0);
    chk("flush in_ready", in_ready, 1);
    cycle(0, 2'd0, 16'h0, 1, 0);
    chk("flush input dropped", out_valid, 0);

    // Reset while holding two results discards them.
    cycle(1, 2'd1, 16'h4444, 0, 0);
    cycle(1, 2'd1, 16'hC444, 0, 0);
    do_reset();
    chk("mid-reset discard", out_valid, 0);

    // Random traffic against the reference queue.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 16'($urandom),
            $urandom_range(0, 2) != 0, $urandom_range(0, 49) == 0);
    end

`ifdef IMM_EXTEND_PIPE_CNT_EN
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1, 2'd0, 16'(i), 1, 0);
    cycle(0, 2'd0, 16'h0, 1, 0);
    chk("cnt five", xfer_cnt, 16'd5);
    do_reset();
    chk("cnt cleared", xfer_cnt, 16'd0);
    for (int i = 0; i < 65540; i++) cycle(1, 2'd0, 16'(i), 1, 0);
    chk("cnt saturated", xfer_cnt, 16'hFFFF);
    cycle(1, 2'd0, 16'h0, 1, 0);
    chk("cnt stays saturated", xfer_cnt, 16'hFFFF);
    cycle(0, 2'd0, 16'h0, 0, 1);
    chk("cnt flush clear", xfer_cnt, 16'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/imm_extend_pipe.md
IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

Interface
REQ-001 Parameter IN_W, default 16, immediate input width; SHALL be >= 1.
REQ-002 Parameter OUT_W, default 32, extended output width; SHALL be >= IN_W.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 flush  input  1  synchronous clear of all buffered entries.
REQ-006 in_valid  input  1  producer has an immediate.
REQ-007 in_ready  output  1  block can accept an immediate.
REQ-008 in_imm  input  IN_W  raw immediate.
REQ-009 in_mode  input  2  extension mode: 00 zero, 01 sign, 10 upper, 11 reserved.
REQ-010 out_valid  output  1  out_data/out_err hold a result.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 out_data  output  OUT_W  extended immediate.
REQ-013 out_err  output  1  result came from reserved mode 11.

Function
REQ-014 Transfer occurs on an edge where valid and ready are both high; SHALL apply independently on input and output sides.
REQ-015 Zero mode SHALL produce {(OUT_W-IN_W) zeros, in_imm}.
REQ-016 Sign mode SHALL produce in_imm with bit IN_W-1 replicated into all upper bits.
REQ-017 Upper mode SHALL produce in_imm in bits OUT_W-1..OUT_W-IN_W, zeros below; with OUT_W==IN_W it SHALL equal in_imm.
REQ-018 Reserved mode SHALL produce zero-mode data with out_err=1; all other modes out_err=0.
REQ-019 Extension SHALL be computed at acceptance and stored; latency from input transfer to out_valid SHALL be exactly 1 cycle.
REQ-020 Storage SHALL be a 2-entry skid buffer: main entry drives outputs, skid entry holds one overflow result.
REQ-021 in_ready SHALL be registered and equal NOT(skid entry occupied); no combinational path out_ready->in_ready.
REQ-022 Sustained throughput SHALL be one transfer per cycle while out_ready stays high.
REQ-023 When out_ready drops with main full and an input accepted same cycle, that result SHALL go to the skid entry; in_ready SHALL deassert next cycle.
REQ-024 On output transfer with skid occupied, skid SHALL move to main next cycle and in_ready SHALL reassert; order SHALL be strictly FIFO.
REQ-025 Simultaneous input and output transfer with skid empty SHALL load main with the new result, out_valid remaining 1.
REQ-026 out_data/out_err SHALL be stable while out_valid=1 and out_ready=0.
REQ-027 flush SHALL empty both entries next cycle, discarding any same-cycle input; in_ready SHALL be 1 after flush.

Reset
REQ-028 rst_n low SHALL immediately force out_valid=0, out_data=0, out_err=0, in_ready=0, both entries empty.
REQ-029 First edge with rst_n high SHALL set in_ready=1; reset asserted mid-transfer SHALL discard all buffered results.

Configuration
REQ-030 Macro IMM_EXTEND_PIPE_CNT_EN, when defined, SHALL add output xfer_cnt (16 bits): count of output transfers, saturating at 0xFFFF, cleared by reset and flush.
REQ-031 Without IMM_EXTEND_PIPE_CNT_EN, xfer_cnt and its logic SHALL be absent; all other behaviour identical.

Structure
REQ-032 Shared package imm_ext_pkg SHALL hold mode encodings (MODE_ZERO, MODE_SIGN, MODE_UPPER, MODE_RSVD) and default widths.
REQ-033 Combinational extension logic SHALL be sub-module imm_ext_core (inputs imm, mode; outputs data, err); buffering stays in imm_extend_pipe.

Verification
REQ-034 Defaults, mode 01, in_imm 0x8001, out_ready=1 -> next cycle out_data 0xFFFF8001, out_err 0.
REQ-035 Mode 00 0x8001 then mode 10 0x1234 back-to-back -> 0x00008001 then 0x12340000 on consecutive cycles.
REQ-036 out_ready held 0, three valid inputs -> two accepted, in_ready low from cycle 2; release out_ready -> both emitted in order, in_ready back to 1.
REQ-037 Mode 11 in_imm 0x00FF -> out_data 0x000000FF, out_err 1.
REQ-038 Two entries buffered, flush pulsed with in_valid=1 -> out_valid 0 next cycle, input dropped, in_ready 1.
REQ-039 With IMM_EXTEND_PIPE_CNT_EN, 5 output transfers then reset -> xfer_cnt 5 then 0; counter preloaded at 0xFFFF stays 0xFFFF.
